gsim_residual_check: RTL and testbench
======================================

# gsim_residual_check

Downstream checker for the Gauss-Seidel solver. It captures the 16 right-hand-side values fed to the solver and the 16 Q16.16 solution words it returns, then computes the residual r = b·2^16 − A·x row by row against the fixed banded matrix. It streams each row residual, then reports the maximum absolute residual and a pass flag against a tolerance. It sits on the solver's output, snooping the solver's input stream in parallel.

## Interface
- TOL, 32'd655 — pass threshold on |r_i|, Q16.16 (≈0.01)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- b_en  in  1  b sample strobe (same strobe that feeds the solver)
- b_in  in  16  signed integer b sample
- x_valid  in  1  solver output valid
- x_in  in  32  signed Q16.16 solution word
- res_valid  out  1  row residual valid
- res_idx  out  4  row index of res_out
- res_out  out  40  signed Q16.16 residual of row res_idx
- done  out  1  one-cycle pulse: summary valid
- max_abs  out  40  max |r_i| over the frame, held until next done
- pass  out  1  max_abs <= TOL, held until next done
- b_drop  out  1  sticky: b_en seen while b buffer full; cleared by reset only

## Operation
- Matrix is fixed: A[i][i]=20, A[i][i±1]=−13, A[i][i±2]=6, A[i][i±3]=−1; out-of-range taps are zero (rows 0–2, 13–15 truncated).
- B capture: b_cnt 0..16. Each b_en with b_cnt<16 stores b_in at b_buf[b_cnt], b_cnt+1. With b_cnt==16, b_en is ignored and sets b_drop.
- X capture: x_cnt 0..16. Each x_valid with x_cnt<16 stores x_in at x_buf[x_cnt]. Beats after the 16th are discarded while x_valid stays high. Capture re-arms only after x_valid has been low for ≥1 cycle.
- The B and X captures are independent, so either stream may complete first.
- FSM states:
  - COLLECT → COMPUTE when b_cnt==16 and x_cnt==16, evaluated on registered counts.
  - COMPUTE, row 0..15, one row per cycle → REPORT after row 15.
  - REPORT, one cycle: done=1 → COLLECT with b_cnt=x_cnt=0.
- b_en or x_valid during COMPUTE/REPORT is ignored. b_en additionally sets b_drop. x_valid keeps the re-arm requirement.
- Arithmetic:
  - Sign-extend all terms to 40 bits.
  - Products use shift-add only: 20x=(x<<4)+(x<<2), 13x=(x<<3)+(x<<2)+x, 6x=(x<<2)+(x<<1).
  - r_i = (sext(b_i)<<16) − Σ A_ij·x_j. No overflow is possible in 40 bits.
  - |r| is computed in 40 bits. The most negative value saturates to 2^39−1.
- max_abs accumulator clears at COMPUTE entry and updates with each row.

## Timing
- Reset values: res_valid=0, res_idx=0, res_out=0, done=0, max_abs=0, pass=0, b_drop=0, b_cnt=x_cnt=0, state COLLECT.
- The edge that completes the second capture (edge E) moves the FSM to COMPUTE.
- Row i is registered on edge E+1+i: res_valid=1 and res_idx=i for 16 consecutive cycles.
- done is high for the cycle after edge E+17. max_abs/pass update on that same edge.
- All outputs are registered. No combinational input-to-output path.
- Reset mid-frame aborts immediately. Buffers are not cleared but are unreachable until refilled.
- b_en and x_valid arriving on the same edge are both accepted.

## Structure
- Package gsim_pkg:
  - N=16, B_W=16, X_W=32, ACC_W=40, FRAC=16
  - tap coefficient constants (20, −13, 6, −1)
  - FSM state typedef
- Sub-module gsim_band_row, combinational:
  - inputs: row index, b_i, x_buf window x[i−3..i+3] with validity mask
  - output: r_i
- Top level: two capture buffers, counters, FSM, max/pass logic.

## Test plan
- b all 0, x all 0 → 16 residuals 0, max_abs=0, pass=1, done exactly 17 cycles after last capture.
- b all 0, x all 0x00010000 → res[0]=−786432, res[1]=+65536, res[3..12]=−262144; max_abs=786432, pass=0.
- b = row sums of A (12, −1, 5, 4×10, 5, −1, 12), x all 1.0 → all residuals 0, pass=1.
- x stream of 17 beats (17th = 0xDEADBEEF) → 17th discarded, results identical to the 16-beat case. A new frame before x_valid drops is not captured.
- x stream completes before b stream, and b_en is gapped (idle cycles between samples) → COMPUTE starts on the 16th b edge. An extra b_en during COMPUTE sets b_drop=1 and leaves results unchanged.
- reset asserted at row 7 of COMPUTE → all outputs 0 the next cycle. A following full frame produces correct results.

Source files
------------

// File: rtl/gsim_residual_check_pkg.sv
// Shared sizes, band-matrix taps and helpers for the Gauss-Seidel residual checker.
package gsim_pkg;

  localparam int N     = 16;
  localparam int B_W   = 16;
  localparam int X_W   = 32;
  localparam int ACC_W = 40;
  localparam int FRAC  = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  localparam int TAP0 = 20;
  localparam int TAP1 = -13;
  localparam int TAP2 = 6;
  localparam int TAP3 = -1;

  // Coefficient for window slot k, where slot k holds x[row-3+k].
  localparam int TAPS [7] = '{TAP3, TAP2, TAP1, TAP0, TAP1, TAP2, TAP3};

  localparam logic [31:0] TOL = 32'd655;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_COMPUTE,
    ST_REPORT
  } state_e;

  function automatic logic signed [ACC_W-1:0] mul_tap(input logic signed [ACC_W-1:0] x,
                                                      input int tap);
    case (tap)
      TAP0:    mul_tap = (x <<< 4) + (x <<< 2);
      TAP1:    mul_tap = -((x <<< 3) + (x <<< 2) + x);
      TAP2:    mul_tap = (x <<< 2) + (x <<< 1);
      TAP3:    mul_tap = -x;
      default: mul_tap = '0;
    endcase
  endfunction

  // The most negative value has no positive twin, so it saturates.
  function automatic logic [ACC_W-1:0] abs_sat(input logic signed [ACC_W-1:0] v);
    if (v == {1'b1, {(ACC_W-1){1'b0}}})
      abs_sat = {1'b0, {(ACC_W-1){1'b1}}};
    else if (v[ACC_W-1])
      abs_sat = -v;
    else
      abs_sat = v;
  endfunction

endpackage

// File: rtl/gsim_residual_check_band_row.sv
// One row of the banded residual r_i = (b_i << 16) - sum_j A[i][j] * x_j, combinational.
module gsim_band_row
  import gsim_pkg::*;
(
  input  logic        [IDX_W-1:0]     row_i,
  input  logic signed [B_W-1:0]       b_i,
  input  logic        [6:0][X_W-1:0]  x_win_i,
  output logic signed [ACC_W-1:0]     r_o
);

  logic [6:0]               mask;
  logic [5:0]               pos;
  logic signed [ACC_W-1:0]  xs;
  logic signed [ACC_W-1:0]  acc;

  always_comb begin
    mask = '0;
    pos  = '0;
    xs   = '0;
    acc  = {{(ACC_W-B_W-FRAC){b_i[B_W-1]}}, b_i, {FRAC{1'b0}}};
    for (int k = 0; k < 7; k++) begin
      // Slot k maps to column row+k-3; taps falling outside 0..15 are dropped.
      pos     = {2'b00, row_i} + 6'(k);
      mask[k] = (pos >= 6'd3) && (pos <= 6'd18);
      xs      = {{(ACC_W-X_W){x_win_i[k][X_W-1]}}, x_win_i[k]};
      if (mask[k])
        acc = acc - mul_tap(xs, TAPS[k]);
    end
    r_o = acc;
  end

endmodule

// File: rtl/gsim_residual_check.sv
// Snoops the solver's b stream and x results, then streams per-row residuals and a max/pass summary.
module gsim_residual_check
  import gsim_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              b_en,
  input  logic [B_W-1:0]    b_in,
  input  logic              x_valid,
  input  logic [X_W-1:0]    x_in,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [ACC_W-1:0]  res_out,
  output logic              done,
  output logic [ACC_W-1:0]  max_abs,
  output logic              pass,
  output logic              b_drop
);

  state_e                   state_q;
  logic [CNT_W-1:0]         b_cnt_q, b_cnt_d;
  logic [CNT_W-1:0]         x_cnt_q, x_cnt_d;
  logic                     x_armed_q, x_armed_d;
  logic [IDX_W-1:0]         row_q;
  logic [ACC_W-1:0]         acc_max_q;
  logic                     res_valid_q;
  logic [IDX_W-1:0]         res_idx_q;
  logic [ACC_W-1:0]         res_out_q;
  logic                     done_q;
  logic [ACC_W-1:0]         max_abs_q;
  logic                     pass_q;
  logic                     b_drop_q;

  logic [B_W-1:0]           b_buf [N];
  logic [X_W-1:0]           x_buf [N];

  logic                     b_take;
  logic                     x_take;
  logic [6:0][X_W-1:0]      x_win;
  logic [IDX_W-1:0]         widx;
  logic signed [ACC_W-1:0]  r_row;
  logic [ACC_W-1:0]         r_abs;

  assign b_take  = b_en && (state_q == ST_COLLECT) && (b_cnt_q < CNT_W'(N));
  assign x_take  = x_valid && x_armed_q && (state_q == ST_COLLECT) && (x_cnt_q < CNT_W'(N));
  assign b_cnt_d = b_cnt_q + CNT_W'(b_take);
  assign x_cnt_d = x_cnt_q + CNT_W'(x_take);

  // A burst stays blocked after its 16th beat (or while the FSM is busy) until x_valid drops.
  always_comb begin
    x_armed_d = x_armed_q;
    if (!x_valid)
      x_armed_d = 1'b1;
    else if (state_q != ST_COLLECT)
      x_armed_d = 1'b0;
    else if (x_take && (x_cnt_q == CNT_W'(N-1)))
      x_armed_d = 1'b0;
  end

  always_comb begin
    widx  = '0;
    x_win = '0;
    for (int k = 0; k < 7; k++) begin
      widx     = row_q + IDX_W'(k) - IDX_W'(3);
      x_win[k] = x_buf[widx];
    end
  end

  gsim_band_row u_row (
    .row_i   (row_q),
    .b_i     (b_buf[row_q]),
    .x_win_i (x_win),
    .r_o     (r_row)
  );

  assign r_abs = abs_sat(r_row);

  always_ff @(posedge clk) begin
    if (b_take)
      b_buf[b_cnt_q[IDX_W-1:0]] <= b_in;
    if (x_take)
      x_buf[x_cnt_q[IDX_W-1:0]] <= x_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_COLLECT;
      b_cnt_q     <= '0;
      x_cnt_q     <= '0;
      x_armed_q   <= 1'b0;
      row_q       <= '0;
      acc_max_q   <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_out_q   <= '0;
      done_q      <= 1'b0;
      max_abs_q   <= '0;
      pass_q      <= 1'b0;
      b_drop_q    <= 1'b0;
    end else begin
      b_cnt_q     <= b_cnt_d;
      x_cnt_q     <= x_cnt_d;
      x_armed_q   <= x_armed_d;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (b_en && !b_take)
        b_drop_q <= 1'b1;
      case (state_q)
        ST_COLLECT: begin
          if ((b_cnt_d == CNT_W'(N)) && (x_cnt_d == CNT_W'(N))) begin
            state_q   <= ST_COMPUTE;
            row_q     <= '0;
            acc_max_q <= '0;
          end
        end
        ST_COMPUTE: begin
          res_valid_q <= 1'b1;
          res_idx_q   <= row_q;
          res_out_q   <= r_row;
          if (r_abs > acc_max_q)
            acc_max_q <= r_abs;
          row_q <= row_q + 1'b1;
          if (row_q == IDX_W'(N-1))
            state_q <= ST_REPORT;
        end
        ST_REPORT: begin
          done_q    <= 1'b1;
          max_abs_q <= acc_max_q;
          pass_q    <= (acc_max_q <= ACC_W'(TOL));
          b_cnt_q   <= '0;
          x_cnt_q   <= '0;
          state_q   <= ST_COLLECT;
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_out   = res_out_q;
  assign done      = done_q;
  assign max_abs   = max_abs_q;
  assign pass      = pass_q;
  assign b_drop    = b_drop_q;

endmodule

// File: tb/tb_gsim_residual_check.sv
// Directed scoreboard bench for gsim_residual_check: expected rows/summaries queued at stimulus time.
module tb_gsim_residual_check;

  logic        clk = 1'b0;
  logic        reset;
  logic        b_en;
  logic [15:0] b_in;
  logic        x_valid;
  logic [31:0] x_in;
  logic        res_valid;
  logic [3:0]  res_idx;
  logic [39:0] res_out;
  logic        done;
  logic [39:0] max_abs;
  logic        pass;
  logic        b_drop;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // {cycle, idx, residual} and {cycle, max_abs, pass}
  logic [75:0] res_q [$];
  logic [72:0] sum_q [$];
  logic [75:0] e_r;
  logic [72:0] e_s;

  logic signed [15:0] bv [16];
  logic        [31:0] xv [16];

  gsim_residual_check dut (
    .clk       (clk),
    .reset     (reset),
    .b_en      (b_en),
    .b_in      (b_in),
    .x_valid   (x_valid),
    .x_in      (x_in),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res_out   (res_out),
    .done      (done),
    .max_abs   (max_abs),
    .pass      (pass),
    .b_drop    (b_drop)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int coef(input int i, input int j);
    int d;
    d = (i > j) ? i - j : j - i;
    case (d)
      0:       coef = 20;
      1:       coef = -13;
      2:       coef = 6;
      3:       coef = -1;
      default: coef = 0;
    endcase
  endfunction

  // k is the cycle count seen when the completing beat was driven.
  task automatic push_expected(input int k);
    longint r, ar, m;
    m = 0;
    for (int i = 0; i < 16; i++) begin
      r = longint'(bv[i]) * 65536;
      for (int j = 0; j < 16; j++)
        r = r - longint'(coef(i, j)) * longint'($signed(xv[j]));
      ar = (r < 0) ? -r : r;
      if (ar > m) m = ar;
      res_q.push_back({32'(k + 2 + i), 4'(i), 40'(r)});
    end
    sum_q.push_back({32'(k + 18), 40'(m), (m <= 655)});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL residual_unexpected: got row %0d value %h, expected none", res_idx, res_out);
      end else begin
        e_r = res_q.pop_front();
        check("residual", {32'(cyc), res_idx, res_out}, e_r);
      end
    end
    if (done === 1'b1) begin
      if (sum_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL summary_unexpected: got max_abs %h pass %b, expected none", max_abs, pass);
      end else begin
        e_s = sum_q.pop_front();
        check("summary", {3'b000, 32'(cyc), max_abs, pass}, {3'b000, e_s});
      end
    end
  end

  // ---------------- drivers ----------------
  // mode 0: b then x; 1: simultaneous; 2: x first, gapped b, extra b_en in COMPUTE;
  // 3: x burst with 17th beat and a stray tail held high across the frame.
  task automatic drive_frame(input int mode);
    int k;
    int gap;
    k = 0;
    case (mode)
      0: begin
        for (int i = 0; i < 16; i++) begin
          b_en = 1'b1; b_in = bv[i]; tick;
        end
        b_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
          x_valid = 1'b1; x_in = xv[i];
          if (i == 15) begin k = cyc; push_expected(k); end
          tick;
        end
        x_valid = 1'b0;
      end
      1: begin
        for (int i = 0; i < 16; i++) begin
          b_en = 1'b1; b_in = bv[i]; x_valid = 1'b1; x_in = xv[i];
          if (i == 15) begin k = cyc; push_expected(k); end
          tick;
        end
        b_en = 1'b0; x_valid = 1'b0;
      end
      2: begin
        for (int i = 0; i < 16; i++) begin
          x_valid = 1'b1; x_in = xv[i]; tick;
        end
        x_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
          b_en = 1'b1; b_in = bv[i];
          if (i == 15) begin k = cyc; push_expected(k); end
          tick;
          b_en = 1'b0;
          gap = (i == 15) ? 0 : $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) tick;
        end
        for (int g = 0; g < 3; g++) tick;
        b_en = 1'b1; b_in = 16'h7FFF; tick;
        b_en = 1'b0;
        check("b_drop_set", 76'(b_drop), 76'(1));
      end
      default: begin
        for (int c = 0; c < 58; c++) begin
          x_valid = 1'b1;
          x_in    = (c < 16) ? xv[c] : ((c == 16) ? 32'hDEADBEEF : 32'h1234_0000 + 32'(c));
          b_en    = (c >= 17) && (c < 33);
          b_in    = (c >= 17 && c < 33) ? bv[c - 17] : 16'h0;
          if (c == 32) begin k = cyc; push_expected(k); end
          tick;
        end
        x_valid = 1'b0; b_en = 1'b0;
      end
    endcase
  endtask

  task automatic wait_frame(input string name);
    int t;
    t = 0;
    while ((res_q.size() != 0 || sum_q.size() != 0) && t < 200) begin
      tick;
      t++;
    end
    check({name, "_drained"}, 76'(res_q.size() + sum_q.size()), 76'(0));
    res_q.delete();
    sum_q.delete();
    tick;
    tick;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_res_valid"}, 76'(res_valid), 76'(0));
    check({name, "_res_idx"},   76'(res_idx),   76'(0));
    check({name, "_res_out"},   76'(res_out),   76'(0));
    check({name, "_done"},      76'(done),      76'(0));
    check({name, "_max_abs"},   76'(max_abs),   76'(0));
    check({name, "_pass"},      76'(pass),      76'(0));
    check({name, "_b_drop"},    76'(b_drop),    76'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    reset = 1'b1; b_en = 1'b0; b_in = '0; x_valid = 1'b0; x_in = '0;
    tick; tick; tick;
    check_outputs_zero("reset");
    reset = 1'b0;
    tick;

    // zero frame
    for (int i = 0; i < 16; i++) begin bv[i] = 0; xv[i] = 32'h0; end
    drive_frame(0);
    wait_frame("zeros");

    // b = 0, x = 1.0, simultaneous streams
    for (int i = 0; i < 16; i++) begin bv[i] = 0; xv[i] = 32'h0001_0000; end
    drive_frame(1);
    wait_frame("ones");

    // b = row sums, x = 1.0
    bv = '{16'sd12, -16'sd1, 16'sd5, 16'sd4, 16'sd4, 16'sd4, 16'sd4, 16'sd4,
           16'sd4, 16'sd4, 16'sd4, 16'sd4, 16'sd4, 16'sd5, -16'sd1, 16'sd12};
    drive_frame(0);
    wait_frame("rowsum");

    // 17-beat x burst with stray tail, same data as the ones frame
    for (int i = 0; i < 16; i++) begin bv[i] = 0; xv[i] = 32'h0001_0000; end
    drive_frame(3);
    wait_frame("burst17");

    // stray tail must not have been captured
    for (int i = 0; i < 16; i++) begin bv[i] = 0; xv[i] = 32'h0; end
    drive_frame(0);
    wait_frame("after_stray");
    check("b_drop_clear", 76'(b_drop), 76'(0));

    // tolerance boundary: max |r| = 655 then 656
    for (int i = 0; i < 16; i++) begin bv[i] = 0; xv[i] = 32'h0; end
    xv[5] = 32'd15; xv[8] = -32'sd32;
    drive_frame(0);
    wait_frame("tol_655");
    xv[5] = 32'd16;
    drive_frame(1);
    wait_frame("tol_656");

    // mixed extremes, x first then gapped b, extra b_en during COMPUTE
    bv = '{16'sd100, -16'sd200, 16'sd32767, -16'sd32768, 16'sd0, 16'sd5, -16'sd5, 16'sd1234,
           -16'sd1234, 16'sd7, 16'sd8, 16'sd9, -16'sd10, 16'sd11, -16'sd12, 16'sd13};
    xv = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_8000, 32'hFFFE_8000, 32'h0000_0001, 32'hFFFF_FFFF,
           32'h0010_0000, 32'h0000_0000, 32'h1234_5678, 32'hEDCB_A988, 32'h0003_0000, 32'hFFFD_0000,
           32'h0000_FFFF, 32'h8000_0001, 32'h4000_0000, 32'hC000_0000};
    drive_frame(2);
    wait_frame("mixed_gapped");

    // reset while row 7 is being computed
    drive_frame(1);
    t = 0;
    while (!(res_valid === 1'b1 && res_idx == 4'd6) && t < 100) begin
      tick;
      t++;
    end
    check("reach_row7", 76'(res_idx), 76'(6));
    reset = 1'b1;
    tick;
    res_q.delete();
    sum_q.delete();
    check_outputs_zero("midreset");
    reset = 1'b0;
    tick;

    // full frame after the aborted one
    bv = '{-16'sd3, 16'sd1, 16'sd4, -16'sd1, 16'sd5, -16'sd9, 16'sd2, 16'sd6,
           -16'sd5, 16'sd3, 16'sd5, -16'sd8, 16'sd9, 16'sd7, -16'sd9, 16'sd3};
    for (int i = 0; i < 16; i++) xv[i] = 32'h0000_4000 * 32'(i) - 32'h0002_0000;
    drive_frame(0);
    wait_frame("post_reset");
    check("b_drop_after_reset", 76'(b_drop), 76'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
